// File: rtl/block_pixel_unpacker.sv
// Buffers wide plaintext blocks in a small FIFO and serialises them MSB-byte-first
// onto a valid/ready pixel stream, marking image boundaries with tlast/frame_done.
module block_pixel_unpacker #(
  parameter int DATA_WIDTH = 256,
  parameter int PIX_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_PIXELS = 65536
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [PIX_WIDTH-1:0]          m_tdata,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int BPB = DATA_WIDTH / PIX_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int IW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int PW  = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [IW-1:0] IDX_LAST   = IW'(BPB - 1);
  localparam logic [PW-1:0] PCNT_LAST  = PW'(IMG_PIXELS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [IW-1:0]         idx_reg;
  logic [PW-1:0]         pcnt_reg;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  frame_done_reg;

  logic fifo_empty, fifo_full, xfer, pop, push, drop;
  logic [PIX_WIDTH-1:0] pix_arr [BPB];

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LEVEL_FULL);
  assign xfer       = valid_reg && m_tready;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign pop  = !clear && !fifo_empty &&
                ((state_reg == IDLE) || (xfer && (idx_reg == IDX_LAST)));
  assign push = in_valid && !clear && (!fifo_full || pop);
  assign drop = in_valid && !clear && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      idx_reg        <= '0;
      pcnt_reg       <= '0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      pcnt_reg       <= '0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= xfer && (pcnt_reg == PCNT_LAST);
      if (drop) overflow_reg <= 1'b1;
      if (xfer) pcnt_reg <= (pcnt_reg == PCNT_LAST) ? '0 : pcnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            hold_reg  <= mem[rd_ptr_reg];
            idx_reg   <= '0;
            state_reg <= SEND;
            valid_reg <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx_reg != IDX_LAST) begin
              idx_reg <= idx_reg + 1'b1;
            end else if (pop) begin
              // Chain straight into the next block with no idle cycle.
              hold_reg <= mem[rd_ptr_reg];
              idx_reg  <= '0;
            end else begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BPB; gi++) begin : g_pix
      assign pix_arr[gi] = hold_reg[DATA_WIDTH-1-gi*PIX_WIDTH -: PIX_WIDTH];
    end
  endgenerate

  assign m_tvalid   = valid_reg;
  assign m_tdata    = pix_arr[idx_reg];
  assign m_tlast    = valid_reg && (pcnt_reg == PCNT_LAST);
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_block_pixel_unpacker.sv
// Directed bench for block_pixel_unpacker with a queue-based reference model
// compared every cycle, plus literal checks on the pixel streams collected.
module tb_block_pixel_unpacker;
  localparam int DW  = 256;
  localparam int PW  = 8;
  localparam int FD  = 4;
  localparam int IMG = 64;
  localparam int BPB = DW / PW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          m_tready = 1'b1;
  logic          m_tvalid;
  logic [PW-1:0] m_tdata;
  logic          m_tlast;
  logic [$clog2(FD):0] fifo_level;
  logic          overflow;
  logic          frame_done;

  block_pixel_unpacker #(
    .DATA_WIDTH(DW), .PIX_WIDTH(PW), .FIFO_DEPTH(FD), .IMG_PIXELS(IMG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .fifo_level(fifo_level), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkblk(input int k);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < BPB; i++) b[DW-1-8*i -: 8] = 8'(((k & 7) << 5) | i);
    return b;
  endfunction

  // Reference model: FIFO as a queue of blocks, output stage as (block, position).
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_cur = '0;
  bit  m_busy = 0, m_ovf = 0, m_fd = 0, m_xfer, m_pop;
  int  m_pos = 0, m_pix = 0, m_sz;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete(); m_cur = '0; m_busy = 0; m_pos = 0; m_pix = 0; m_ovf = 0; m_fd = 0;
    end else if (clear) begin
      mq.delete(); m_busy = 0; m_pos = 0; m_pix = 0; m_ovf = 0; m_fd = 0;
    end else begin
      m_sz   = mq.size();
      m_xfer = m_busy && m_tready;
      m_fd   = m_xfer && (m_pix == IMG - 1);
      m_pop  = (m_sz > 0) && (!m_busy || (m_xfer && m_pos == BPB - 1));
      if (m_xfer) begin
        m_pix = (m_pix + 1) % IMG;
        if (m_pos < BPB - 1) m_pos++;
        else if (!m_pop) m_busy = 0;
      end
      if (m_pop) begin
        m_cur = mq.pop_front(); m_pos = 0; m_busy = 1;
      end
      if (in_valid) begin
        if (m_sz < FD || m_pop) mq.push_back(in_data);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("tvalid", 32'(m_tvalid), 32'(m_busy));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      if (m_busy) begin
        chk("tdata", 32'(m_tdata), 32'(m_cur[DW-1-m_pos*PW -: PW]));
        chk("tlast", 32'(m_tlast), 32'(m_pix == IMG - 1));
      end
    end
  end

  // Stream collector.
  logic [7:0] rx_data[$];
  bit         rx_last[$];
  int         rx_cyc[$];
  int         max_level = 0;
  int         fd_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_tvalid && m_tready) begin
        rx_data.push_back(m_tdata); rx_last.push_back(m_tlast); rx_cyc.push_back(cyc);
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (frame_done) fd_cnt++;
    end
  end

  int ready_mode = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
      default: m_tready = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      in_valid = 1'b1; in_data = mkblk(k); tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_last.delete(); rx_cyc.delete(); max_level = 0; fd_cnt = 0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int t = 0;
    while (rx_data.size() < n && t < 3000) begin tick(1); t++; end
    chk({name, "_count"}, 32'(rx_data.size() >= n), 32'd1);
  endtask

  // mode 0: byte j == j; mode 1: blocks 1.. in order (overflow case)
  task automatic chk_seq(input string name, input int n, input int mode);
    int bad = 0;
    logic [7:0] e;
    for (int j = 0; j < n && j < rx_data.size(); j++) begin
      e = (mode == 0) ? 8'(j) : 8'((((j / BPB) + 1) << 5) | (j % BPB));
      if (rx_data[j] !== e) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic chk_tlast(input string name, input int n);
    int bad = 0;
    for (int j = 0; j < n && j < rx_last.size(); j++)
      if (rx_last[j] != (j % IMG == IMG - 1)) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_tvalid", 32'(m_tvalid), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    tick(1);

    // Single block, latency and ordering
    clear_rx();
    in_valid = 1'b1; in_data = mkblk(0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_tvalid", 32'(m_tvalid), 32'd0);
    chk("lat_n1_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    chk("lat_n2_tvalid", 32'(m_tvalid), 32'd1);
    chk("lat_n2_tdata", 32'(m_tdata), 32'h00);
    wait_rx(32, "single");
    tick(3);
    chk("single_size", 32'(rx_data.size()), 32'd32);
    chk_seq("single_seq", 32, 0);
    chk("single_span", 32'(rx_cyc[31] - rx_cyc[0]), 32'd31);
    chk("single_end_tvalid", 32'(m_tvalid), 32'd0);
    chk("single_end_level", 32'(fifo_level), 32'd0);

    // Backpressure 1,0,0,1
    clear_rx();
    ready_mode = 1;
    send(0, 1);
    wait_rx(32, "bp");
    tick(40);
    chk("bp_size", 32'(rx_data.size()), 32'd32);
    chk_seq("bp_seq", 32, 0);
    ready_mode = 0;
    tick(2);

    // Back-to-back blocks
    clear_rx();
    send(0, 3);
    wait_rx(96, "b2b");
    tick(3);
    chk_seq("b2b_seq", 96, 0);
    chk("b2b_span", 32'(rx_cyc[95] - rx_cyc[0]), 32'd95);
    chk("b2b_peak_level", 32'(max_level), 32'd2);

    // Overflow with stalled output
    ready_mode = 2;
    tick(2);
    clear_rx();
    send(1, 6);
    tick(2);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    ready_mode = 0;
    wait_rx(160, "ovf");
    tick(40);
    chk("ovf_size", 32'(rx_data.size()), 32'd160);
    chk_seq("ovf_seq", 160, 1);

    // Frame marking after a clear
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("frame_clr_overflow", 32'(overflow), 32'd0);
    clear_rx();
    send(0, 4);
    wait_rx(128, "frame");
    tick(3);
    chk_seq("frame_seq", 128, 0);
    chk_tlast("frame_tlast", 128);
    chk("frame_done_count", 32'(fd_cnt), 32'd2);

    // Clear mid-image
    clear_rx();
    send(0, 3);
    wait_rx(10, "clr_pre");
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clr_tvalid", 32'(m_tvalid), 32'd0);
    chk("clr_level", 32'(fifo_level), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    clear_rx();
    send(0, 2);
    wait_rx(64, "clr_post");
    tick(3);
    chk_seq("clr_seq", 64, 0);
    chk_tlast("clr_tlast", 64);

    // Reset mid-image
    clear_rx();
    send(0, 3);
    wait_rx(10, "rst_pre");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    clear_rx();
    send(0, 2);
    wait_rx(64, "rst_post");
    tick(3);
    chk_seq("rst_seq", 64, 0);
    chk_tlast("rst_tlast", 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
